// File: rtl/vfd_pkg.sv
// vfd_pkg: state encoding, default widths and phase constants shared across
// the VFD sine-PWM datapath (ramp controller and PWM generator).
package vfd_pkg;

    localparam int FREQ_W_DEF  = 16;
    localparam int PHASE_W_DEF = 24;
    localparam int AMP_W_DEF   = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCEL = 3'd1,
        ST_RUN   = 3'd2,
        ST_DECEL = 3'd3,
        ST_FAULT = 3'd4
    } vf_state_t;

    // One third of a full turn, rounded to nearest: floor((2^w + 1) / 3).
    function automatic longint phase_third(input int w);
        return ((longint'(1) << w) + 1) / 3;
    endfunction

    localparam longint PHASE_THIRD = phase_third(PHASE_W_DEF);

    // States in which the inverter bridge is driven.
    function automatic logic is_active(input vf_state_t s);
        return (s == ST_ACCEL) || (s == ST_RUN) || (s == ST_DECEL);
    endfunction

endpackage

// File: rtl/samp_edge_sync.sv
// samp_edge_sync: brings the divider's sample clock into the clk_in domain
// and turns each rising edge into a single-cycle sample_tick.
module samp_edge_sync (
    input  logic clk_in,
    input  logic reset,
    input  logic samp_clk,
    output logic sample_tick
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    // Two-flop synchroniser, then a registered rise detect (tick lands 3 edges after the rise).
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_p0     <= 1'b0;
            sync_p1     <= 1'b0;
            prev_p2     <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            sync_p0     <= samp_clk;
            sync_p1     <= sync_p0;
            prev_p2     <= sync_p1;
            sample_tick <= sync_p1 & ~prev_p2;
        end
    end

endmodule

// File: rtl/vf_ramp_ctrl.sv
// vf_ramp_ctrl: V/f speed ramp, three-phase scheduler and bridge-enable
// sequencing for the VFD sine-PWM datapath.
// Build macro VFD_BOOST_EN adds a fixed low-speed voltage boost (V_BOOST) to amp.
module vf_ramp_ctrl
    import vfd_pkg::*;
#(
    parameter int                FREQ_W   = FREQ_W_DEF,
    parameter int                PHASE_W  = PHASE_W_DEF,
    parameter int                AMP_W    = AMP_W_DEF,
    parameter logic [FREQ_W-1:0] FREQ_MAX = FREQ_W'(40000),
    parameter int                RAMP_DIV = 256,
    parameter int                VF_GAIN  = 8,
    parameter int                VF_SHIFT = 10,
    parameter int                AMP_MAX  = 1023,
    parameter int                V_BOOST  = 40
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               samp_clk,
    input  logic               run_en,
    input  logic               dir,
    input  logic               fault,
    input  logic [FREQ_W-1:0]  freq_cmd,
    input  logic [FREQ_W-1:0]  ramp_step,
    output logic               sample_tick,
    output logic [FREQ_W-1:0]  freq_out,
    output logic [PHASE_W-1:0] phase_u,
    output logic [PHASE_W-1:0] phase_v,
    output logic [PHASE_W-1:0] phase_w,
    output logic [AMP_W-1:0]   amp,
    output logic               pwm_en,
    output logic               at_speed,
    output logic [2:0]         state
);

    localparam int CNT_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int PROD_W = FREQ_W + 8;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RAMP_DIV - 1);
    localparam logic [PHASE_W-1:0] THIRD    = (PHASE_W == PHASE_W_DEF) ?
                                              PHASE_W'(PHASE_THIRD) :
                                              PHASE_W'(phase_third(PHASE_W));
`ifdef VFD_BOOST_EN
    localparam int BOOST = V_BOOST;
`else
    // Boost collapses to zero so the amplitude path is identical minus the offset.
    localparam int BOOST = 0 * V_BOOST;
`endif

    // Step toward lim from below; the extra sum bit keeps a large step from wrapping.
    function automatic logic [FREQ_W-1:0] ramp_up(input logic [FREQ_W-1:0] cur,
                                                  input logic [FREQ_W-1:0] step,
                                                  input logic [FREQ_W-1:0] lim);
        logic [FREQ_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (sum > {1'b0, lim})
            return lim;
        else
            return sum[FREQ_W-1:0];
    endfunction

    // Step toward lim from above, floored at zero.
    function automatic logic [FREQ_W-1:0] ramp_down(input logic [FREQ_W-1:0] cur,
                                                    input logic [FREQ_W-1:0] step,
                                                    input logic [FREQ_W-1:0] lim);
        logic [FREQ_W-1:0] diff;
        diff = (cur > step) ? (cur - step) : '0;
        if (diff < lim)
            return lim;
        else
            return diff;
    endfunction

    // Volts-per-hertz scaling with saturation at AMP_MAX.
    function automatic logic [AMP_W-1:0] vf_amp(input logic [FREQ_W-1:0] f);
        logic [PROD_W-1:0] prod;
        logic [PROD_W-1:0] scaled;
        prod   = PROD_W'(f) * PROD_W'(VF_GAIN);
        scaled = (prod >> VF_SHIFT) + PROD_W'(BOOST);
        if (scaled > PROD_W'(AMP_MAX))
            return AMP_W'(AMP_MAX);
        else
            return scaled[AMP_W-1:0];
    endfunction

    vf_state_t          state_q;
    vf_state_t          state_nxt;
    logic [FREQ_W-1:0]  freq_nxt;
    logic               dir_lat;
    logic               dir_nxt;
    logic [CNT_W-1:0]   ramp_cnt;
    logic               ramp_tick;
    logic [FREQ_W-1:0]  cmd_clamp;
    logic [FREQ_W-1:0]  tgt;
    logic [FREQ_W-1:0]  up_val;
    logic [FREQ_W-1:0]  dn_val;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] acc_nxt;

    samp_edge_sync u_sync (
        .clk_in      (clk_in),
        .reset       (reset),
        .samp_clk    (samp_clk),
        .sample_tick (sample_tick)
    );

    assign cmd_clamp = (freq_cmd > FREQ_MAX) ? FREQ_MAX : freq_cmd;
    assign tgt       = run_en ? cmd_clamp : '0;
    assign up_val    = ramp_up(freq_out, ramp_step, tgt);
    assign dn_val    = ramp_down(freq_out, ramp_step, tgt);
    assign ramp_tick = sample_tick && (ramp_cnt == CNT_LAST);
    assign acc_nxt   = acc + PHASE_W'(freq_out);

    assign state    = state_q;
    assign pwm_en   = is_active(state_q);
    assign at_speed = (state_q == ST_RUN);
    assign phase_u  = acc;

    // Ramp prescaler: counts sample ticks only while the bridge is being sequenced.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            ramp_cnt <= '0;
        else if (state_q == ST_IDLE || state_q == ST_FAULT)
            ramp_cnt <= '0;
        else if (sample_tick)
            ramp_cnt <= (ramp_cnt == CNT_LAST) ? '0 : ramp_cnt + 1'b1;
    end

    // Run/stop/fault sequencing and frequency slewing; fault overrides everything.
    always_comb begin
        state_nxt = state_q;
        freq_nxt  = freq_out;
        dir_nxt   = dir_lat;
        if (fault) begin
            state_nxt = ST_FAULT;
            freq_nxt  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    freq_nxt = '0;
                    if (run_en && freq_cmd != '0) begin
                        state_nxt = ST_ACCEL;
                        dir_nxt   = dir;
                    end
                end
                ST_ACCEL: begin
                    if (ramp_tick) begin
                        if (tgt < freq_out || !run_en) begin
                            state_nxt = ST_DECEL;
                        end else begin
                            freq_nxt = up_val;
                            if (up_val == tgt)
                                state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (ramp_tick) begin
                        if (tgt > freq_out)
                            state_nxt = ST_ACCEL;
                        else if (tgt < freq_out || !run_en)
                            state_nxt = ST_DECEL;
                    end
                end
                ST_DECEL: begin
                    if (ramp_tick) begin
                        if (tgt > freq_out) begin
                            state_nxt = ST_ACCEL;
                        end else begin
                            freq_nxt = dn_val;
                            if (dn_val == '0 && !run_en)
                                state_nxt = ST_IDLE;
                            else if (dn_val == tgt && tgt != '0)
                                state_nxt = ST_RUN;
                        end
                    end
                end
                ST_FAULT: begin
                    freq_nxt = '0;
                    if (!run_en)
                        state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    freq_nxt  = '0;
                end
            endcase
        end
    end

    // State, ramped frequency, latched direction, and amplitude tracking the next frequency.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            freq_out <= '0;
            dir_lat  <= 1'b0;
            amp      <= '0;
        end else begin
            state_q  <= state_nxt;
            freq_out <= freq_nxt;
            dir_lat  <= dir_nxt;
            amp      <= is_active(state_nxt) ? vf_amp(freq_nxt) : '0;
        end
    end

    // Phase accumulator advances once per sample while driving; cleared whenever idle.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            phase_v <= '0;
            phase_w <= '0;
        end else if (state_q == ST_IDLE) begin
            acc     <= '0;
            phase_v <= '0;
            phase_w <= '0;
        end else if (sample_tick && pwm_en) begin
            acc     <= acc_nxt;
            phase_v <= dir_lat ? (acc_nxt + THIRD) : (acc_nxt - THIRD);
            phase_w <= dir_lat ? (acc_nxt - THIRD) : (acc_nxt + THIRD);
        end
    end

endmodule

// File: tb/tb_vf_ramp_ctrl.sv
// tb_vf_ramp_ctrl: directed bench for vf_ramp_ctrl with an expectation queue
// filled per sample tick and drained once the DUT has consumed that tick.
module tb_vf_ramp_ctrl;

    localparam logic [23:0] THIRD_M = 24'd5592405;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        samp_clk = 1'b0;
    logic        run_en = 1'b0;
    logic        dir = 1'b0;
    logic        fault = 1'b0;
    logic [15:0] freq_cmd = '0;
    logic [15:0] ramp_step = '0;

    logic        sample_tick;
    logic [15:0] freq_out;
    logic [23:0] phase_u, phase_v, phase_w;
    logic [9:0]  amp;
    logic        pwm_en, at_speed;
    logic [2:0]  state;

    logic        hg_tick;
    logic [15:0] hg_freq;
    logic [23:0] hg_pu, hg_pv, hg_pw;
    logic [9:0]  hg_amp;
    logic        hg_pwm, hg_at;
    logic [2:0]  hg_state;

    vf_ramp_ctrl #(.RAMP_DIV(4)) dut (
        .clk_in(clk_in), .reset(reset), .samp_clk(samp_clk), .run_en(run_en),
        .dir(dir), .fault(fault), .freq_cmd(freq_cmd), .ramp_step(ramp_step),
        .sample_tick(sample_tick), .freq_out(freq_out), .phase_u(phase_u),
        .phase_v(phase_v), .phase_w(phase_w), .amp(amp), .pwm_en(pwm_en),
        .at_speed(at_speed), .state(state)
    );

    vf_ramp_ctrl #(.RAMP_DIV(4), .VF_GAIN(64)) dut_hg (
        .clk_in(clk_in), .reset(reset), .samp_clk(samp_clk), .run_en(run_en),
        .dir(dir), .fault(fault), .freq_cmd(freq_cmd), .ramp_step(ramp_step),
        .sample_tick(hg_tick), .freq_out(hg_freq), .phase_u(hg_pu),
        .phase_v(hg_pv), .phase_w(hg_pw), .amp(hg_amp), .pwm_en(hg_pwm),
        .at_speed(hg_at), .state(hg_state)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int          st_m = 0;
    int          freq_m = 0;
    logic [23:0] acc_m = '0;
    logic        dir_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0: return 32'(freq_out);
            1: return 32'(state);
            2: return 32'(pwm_en);
            3: return 32'(at_speed);
            4: return 32'(amp);
            5: return 32'(phase_u);
            6: return 32'(phase_v);
            7: return 32'(phase_w);
            default: return 'x;
        endcase
    endfunction

    function automatic int vf_m(input int f, input int gain);
        int a;
        a = (f * gain) >> 10;
`ifdef VFD_BOOST_EN
        a = a + 40;
`endif
        if (a > 1023) a = 1023;
        return a;
    endfunction

    function automatic logic active(input int s);
        return (s == 1) || (s == 2) || (s == 3);
    endfunction

    task automatic push(input string t, input int s, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.sel = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // One samp_clk rise; latency and pulse width are checked, then queued expectations drained.
    task automatic samp_tick();
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk_in);
        samp_clk = 1'b1;
        while (sample_tick !== 1'b1 && n < 8) begin
            @(negedge clk_in);
            n++;
        end
        check("tick_lat", 32'(n), 32'd3);
        @(posedge clk_in);
        #1;
        check("tick_width", 32'(sample_tick), 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, obs(e.sel), e.val);
        end
        samp_clk = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic tick(input int f_exp, input int s_exp);
        logic [23:0] pm, pp;
        if (st_m == 0)
            acc_m = '0;
        else if (active(st_m))
            acc_m = acc_m + 24'(freq_m);
        freq_m = f_exp;
        st_m   = s_exp;
        push("freq", 0, 32'(freq_m));
        push("state", 1, 32'(st_m));
        push("pwm_en", 2, 32'(active(st_m)));
        push("at_speed", 3, 32'(st_m == 2));
        push("amp", 4, active(st_m) ? 32'(vf_m(freq_m, 8)) : 32'd0);
        if (active(st_m)) begin
            pm = acc_m - THIRD_M;
            pp = acc_m + THIRD_M;
            push("phase_u", 5, 32'(acc_m));
            push("phase_v", 6, 32'(dir_m ? pp : pm));
            push("phase_w", 7, 32'(dir_m ? pm : pp));
        end
        samp_tick();
    endtask

    task automatic ticks(input int n, input int f_exp, input int s_exp);
        for (int i = 0; i < n; i++) tick(f_exp, s_exp);
    endtask

    task automatic start_run(input int cmd, input int step);
        @(negedge clk_in);
        freq_cmd  = 16'(cmd);
        ramp_step = 16'(step);
        run_en    = 1'b1;
        @(negedge clk_in);
        check("start_state", 32'(state), 32'd1);
        check("start_pwm", 32'(pwm_en), 32'd1);
        check("start_freq", 32'(freq_out), 32'd0);
        st_m   = 1;
        freq_m = 0;
        dir_m  = dir;
        acc_m  = '0;
    endtask

    task automatic run_to_idle(input int f);
        @(negedge clk_in);
        run_en = 1'b0;
        ticks(3, f, 2);
        tick(f, 3);
        ticks(3, f, 3);
        tick(0, 0);
    endtask

    initial begin
        // Reset held from time zero: outputs must all be zero.
        repeat (2) @(negedge clk_in);
        check("rst0_state", 32'(state), 32'd0);
        check("rst0_pwm", 32'(pwm_en), 32'd0);
        @(negedge clk_in);
        reset = 1'b0;

        // Partial accel, then reset lands mid-ACCEL at freq 50.
        start_run(100, 25);
        ticks(3, 0, 1);
        tick(25, 1);
        ticks(3, 25, 1);
        tick(50, 1);
        @(negedge clk_in);
        reset  = 1'b1;
        run_en = 1'b0;
        #1;
        check("rst_freq", 32'(freq_out), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pwm", 32'(pwm_en), 32'd0);
        check("rst_at_speed", 32'(at_speed), 32'd0);
        check("rst_amp", 32'(amp), 32'd0);
        check("rst_phase_u", 32'(phase_u), 32'd0);
        check("rst_phase_v", 32'(phase_v), 32'd0);
        check("rst_phase_w", 32'(phase_w), 32'd0);
        check("rst_tick", 32'(sample_tick), 32'd0);
        @(negedge clk_in);
        reset = 1'b0;
        st_m = 0; freq_m = 0; acc_m = '0; dir_m = 1'b0;
        tick(0, 0);

        // A zero command does not leave IDLE even with run_en high.
        @(negedge clk_in);
        freq_cmd = '0;
        run_en   = 1'b1;
        repeat (3) @(negedge clk_in);
        check("zero_cmd_idle", 32'(state), 32'd0);

        // Accelerate 25/50/75/100, RUN after the 4th ramp tick.
        start_run(100, 25);
        for (int k = 1; k <= 4; k++) begin
            ticks(3, 25 * (k - 1), 1);
            tick(25 * k, (k == 4) ? 2 : 1);
        end

        // Decelerate with step 30: 70, 40, 10, 0 then IDLE.
        @(negedge clk_in);
        ramp_step = 16'd30;
        run_en    = 1'b0;
        ticks(3, 100, 2);
        tick(100, 3);
        ticks(3, 100, 3); tick(70, 3);
        ticks(3, 70, 3);  tick(40, 3);
        ticks(3, 40, 3);  tick(10, 3);
        ticks(3, 10, 3);  tick(0, 0);

        // Phase, forward rotation: 10 ticks at 1000.
        dir = 1'b0;
        start_run(1000, 1000);
        ticks(3, 0, 1);
        tick(1000, 2);
        ticks(10, 1000, 2);
        check("fwd_u", 32'(phase_u), 32'd10000);
        check("fwd_v", 32'(phase_v), 32'd11194811);
        check("fwd_w", 32'(phase_w), 32'd5602405);
        ticks(2, 1000, 2);
        run_to_idle(1000);

        // Phase, reverse rotation; a mid-run dir change must be ignored.
        dir = 1'b1;
        start_run(1000, 1000);
        dir = 1'b0;
        ticks(3, 0, 1);
        tick(1000, 2);
        ticks(10, 1000, 2);
        check("rev_u", 32'(phase_u), 32'd10000);
        check("rev_v", 32'(phase_v), 32'd5602405);
        check("rev_w", 32'(phase_w), 32'd11194811);
        ticks(2, 1000, 2);
        run_to_idle(1000);

        // Command above FREQ_MAX is clamped; large step must not wrap.
        start_run(50000, 30000);
        ticks(3, 0, 1);
        tick(30000, 1);
        @(negedge clk_in);
        ramp_step = 16'd60000;
        ticks(3, 30000, 1);
        tick(40000, 2);
`ifdef VFD_BOOST_EN
        check("amp_40000", 32'(amp), 32'd352);
`else
        check("amp_40000", 32'(amp), 32'd312);
`endif
        check("amp_hg_sat", 32'(hg_amp), 32'd1023);

        // Fault from RUN: coast immediately, stay while run_en held.
        @(negedge clk_in);
        fault = 1'b1;
        @(negedge clk_in);
        check("flt_state", 32'(state), 32'd4);
        check("flt_pwm", 32'(pwm_en), 32'd0);
        check("flt_freq", 32'(freq_out), 32'd0);
        check("flt_amp", 32'(amp), 32'd0);
        st_m = 4; freq_m = 0;
        tick(0, 4);
        fault = 1'b0;
        repeat (3) @(negedge clk_in);
        check("flt_hold_run", 32'(state), 32'd4);
        run_en = 1'b0;
        @(negedge clk_in);
        check("flt_exit", 32'(state), 32'd0);
        st_m = 0;

        // Fault during ACCEL with a partly counted ramp prescaler.
        dir = 1'b0;
        start_run(100, 25);
        ticks(3, 0, 1);
        tick(25, 1);
        ticks(2, 25, 1);
        @(negedge clk_in);
        fault = 1'b1;
        @(negedge clk_in);
        check("flt_acc_state", 32'(state), 32'd4);
        check("flt_acc_pwm", 32'(pwm_en), 32'd0);
        check("flt_acc_freq", 32'(freq_out), 32'd0);
        check("flt_acc_amp", 32'(amp), 32'd0);
        fault  = 1'b0;
        run_en = 1'b0;
        @(negedge clk_in);
        check("flt_acc_exit", 32'(state), 32'd0);
        st_m = 0;

        // Prescaler restarts from zero; then a zero step holds frequency.
        start_run(100, 25);
        ticks(3, 0, 1);
        tick(25, 1);
        @(negedge clk_in);
        ramp_step = '0;
        ticks(4, 25, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
